// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: op types, access sizes, FSM states.
// Alignment helpers are used by the top; the misalignment test only matters with MISALIGN_CHECK_EN.
package mem_pkg;

   typedef enum logic [2:0] {
      MemNone = 3'b000,
      MemLb   = 3'b001,
      MemLh   = 3'b010,
      MemLw   = 3'b011,
      MemLbu  = 3'b101,
      MemLhu  = 3'b110
   } mem_type_e;

   typedef enum logic [1:0] {
      SizeNone = 2'b00,
      SizeB    = 2'b01,
      SizeH    = 2'b10,
      SizeW    = 2'b11
   } mem_size_e;

   typedef enum logic [2:0] {
      StIdle,
      StAReq,
      StAWait,
      StBReq,
      StBWait,
      StDone
   } mau_state_e;

   function automatic logic is_misaligned(mem_size_e size, logic [1:0] lo);
      case (size)
         SizeH:   return lo[0];
         SizeW:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] align_lo(mem_size_e size, logic [1:0] lo);
      case (size)
         SizeH:   return {lo[1], 1'b0};
         SizeW:   return 2'b00;
         default: return lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bundle between the access unit (master) and the dcache (slave).
interface mem_access_unit_if;

   logic        dc_req_valid;
   logic        dc_req_we;
   logic [31:0] dc_req_addr;
   logic [3:0]  dc_req_wstrb;
   logic [31:0] dc_req_wdata;
   logic        dc_req_ready;
   logic        dc_resp_valid;
   logic [31:0] dc_resp_rdata;

   modport master (
      output dc_req_valid,
      output dc_req_we,
      output dc_req_addr,
      output dc_req_wstrb,
      output dc_req_wdata,
      input  dc_req_ready,
      input  dc_resp_valid,
      input  dc_resp_rdata
   );

   modport slave (
      input  dc_req_valid,
      input  dc_req_we,
      input  dc_req_addr,
      input  dc_req_wstrb,
      input  dc_req_wdata,
      output dc_req_ready,
      output dc_resp_valid,
      output dc_resp_rdata
   );

endinterface

// File: rtl/mem_load_align.sv
// Per-slot lane logic: load byte/half select with sign/zero extension, store strobe and
// lane replication. Purely combinational; lo_i is the already-aligned low address.
module mem_load_align
   import mem_pkg::*;
(
   input  mem_size_e   size_i,
   input  logic        sign_i,
   input  logic [1:0]  lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] sdata_i,
   output logic [31:0] ldata_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{lo_i, 3'b000} +: 8];
      half_sel = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      ldata_o  = '0;
      wstrb_o  = 4'b0000;
      wdata_o  = sdata_i;
      case (size_i)
         SizeB: begin
            ldata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            wstrb_o = 4'b0001 << lo_i;
            wdata_o = {4{sdata_i[7:0]}};
         end
         SizeH: begin
            ldata_o = {{16{sign_i & half_sel[15]}}, half_sel};
            wstrb_o = 4'b0011 << {lo_i[1], 1'b0};
            wdata_o = {2{sdata_i[15:0]}};
         end
         SizeW: begin
            ldata_o = rdata_i;
            wstrb_o = 4'b1111;
            wdata_o = sdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Two-slot MEM-stage access unit: serialises slot A then slot B onto one dcache port.
// Define MISALIGN_CHECK_EN to suppress misaligned accesses and raise mem_ale_a/b instead.
module mem_access_unit
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        MEM_mem_type_a,
   input  logic [2:0]        MEM_mem_type_b,
   input  logic              MEM_mem_we_a,
   input  logic              MEM_mem_we_b,
   input  logic [31:0]       MEM_alu_result_a,
   input  logic [31:0]       MEM_alu_result_b,
   input  logic [31:0]       MEM_store_data_a,
   input  logic [31:0]       MEM_store_data_b,
   output logic [31:0]       MEM_rf_wdata_a,
   output logic [31:0]       MEM_rf_wdata_b,
   output logic              stall_dcache,
`ifdef MISALIGN_CHECK_EN
   output logic              mem_ale_a,
   output logic              mem_ale_b,
`endif
   mem_access_unit_if.master dc
);

   mau_state_e  state_q;
   logic [31:0] data_a_q, data_b_q;
   mem_size_e   size_a, size_b;
   logic        memop_a, memop_b, load_a, load_b, mis_a, mis_b, sel_b;
   logic [1:0]  lo_a, lo_b;
   logic [31:0] ld_a, ld_b, wd_a, wd_b;
   logic [3:0]  strb_a, strb_b;

   assign size_a  = mem_size_e'(MEM_mem_type_a[1:0]);
   assign size_b  = mem_size_e'(MEM_mem_type_b[1:0]);
   assign memop_a = MEM_mem_we_a | (MEM_mem_type_a != MemNone);
   assign memop_b = MEM_mem_we_b | (MEM_mem_type_b != MemNone);
   assign load_a  = ~MEM_mem_we_a & (MEM_mem_type_a != MemNone);
   assign load_b  = ~MEM_mem_we_b & (MEM_mem_type_b != MemNone);
   assign lo_a    = align_lo(size_a, MEM_alu_result_a[1:0]);
   assign lo_b    = align_lo(size_b, MEM_alu_result_b[1:0]);

`ifdef MISALIGN_CHECK_EN
   logic ale_a_q, ale_b_q;
   assign mis_a     = is_misaligned(size_a, MEM_alu_result_a[1:0]);
   assign mis_b     = is_misaligned(size_b, MEM_alu_result_b[1:0]);
   assign mem_ale_a = (state_q == StDone) & ale_a_q;
   assign mem_ale_b = (state_q == StDone) & ale_b_q;
`else
   assign mis_a = 1'b0;
   assign mis_b = 1'b0;
`endif

   mem_load_align u_align_a (
      .size_i  (size_a),
      .sign_i  (~MEM_mem_type_a[2]),
      .lo_i    (lo_a),
      .rdata_i (dc.dc_resp_rdata),
      .sdata_i (MEM_store_data_a),
      .ldata_o (ld_a),
      .wstrb_o (strb_a),
      .wdata_o (wd_a)
   );

   mem_load_align u_align_b (
      .size_i  (size_b),
      .sign_i  (~MEM_mem_type_b[2]),
      .lo_i    (lo_b),
      .rdata_i (dc.dc_resp_rdata),
      .sdata_i (MEM_store_data_b),
      .ldata_o (ld_b),
      .wstrb_o (strb_b),
      .wdata_o (wd_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         data_a_q <= '0;
         data_b_q <= '0;
`ifdef MISALIGN_CHECK_EN
         ale_a_q  <= 1'b0;
         ale_b_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
`ifdef MISALIGN_CHECK_EN
               ale_a_q <= 1'b0;
               ale_b_q <= 1'b0;
`endif
               if (memop_a) state_q <= StAReq;
               else if (memop_b) state_q <= StBReq;
            end
            StAReq: begin
               // A misaligned op never reaches the dcache; it completes here with zero data.
               if (mis_a) begin
                  data_a_q <= '0;
`ifdef MISALIGN_CHECK_EN
                  ale_a_q  <= 1'b1;
`endif
                  state_q  <= memop_b ? StBReq : StDone;
               end else if (dc.dc_req_ready) begin
                  state_q <= StAWait;
               end
            end
            StAWait: begin
               if (dc.dc_resp_valid) begin
                  data_a_q <= load_a ? ld_a : '0;
                  state_q  <= memop_b ? StBReq : StDone;
               end
            end
            StBReq: begin
               if (mis_b) begin
                  data_b_q <= '0;
`ifdef MISALIGN_CHECK_EN
                  ale_b_q  <= 1'b1;
`endif
                  state_q  <= StDone;
               end else if (dc.dc_req_ready) begin
                  state_q <= StBWait;
               end
            end
            StBWait: begin
               if (dc.dc_resp_valid) begin
                  data_b_q <= load_b ? ld_b : '0;
                  state_q  <= StDone;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      sel_b           = (state_q == StBReq);
      stall_dcache    = (state_q == StIdle) ? (memop_a | memop_b) : (state_q != StDone);
      dc.dc_req_valid = ((state_q == StAReq) & ~mis_a) | ((state_q == StBReq) & ~mis_b);
      dc.dc_req_we    = sel_b ? MEM_mem_we_b : MEM_mem_we_a;
      dc.dc_req_addr  = sel_b ? {MEM_alu_result_b[31:2], lo_b} : {MEM_alu_result_a[31:2], lo_a};
      dc.dc_req_wstrb = sel_b ? strb_b : strb_a;
      dc.dc_req_wdata = sel_b ? wd_b : wd_a;
      MEM_rf_wdata_a  = load_a ? data_a_q : MEM_alu_result_a;
      MEM_rf_wdata_b  = load_b ? data_b_q : MEM_alu_result_b;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a cycle-level dcache responder and hand-computed
// expectations; the misalignment vector depends on MISALIGN_CHECK_EN.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  type_a, type_b;
   logic        we_a, we_b;
   logic [31:0] alu_a, alu_b, sd_a, sd_b, rf_a, rf_b;
   logic        stall;
`ifdef MISALIGN_CHECK_EN
   logic        ale_a, ale_b;
   logic        done_ale_a;
`endif

   mem_access_unit_if dc ();

   mem_access_unit dut (
      .clk              (clk),
      .rst              (rst),
      .MEM_mem_type_a   (type_a),
      .MEM_mem_type_b   (type_b),
      .MEM_mem_we_a     (we_a),
      .MEM_mem_we_b     (we_b),
      .MEM_alu_result_a (alu_a),
      .MEM_alu_result_b (alu_b),
      .MEM_store_data_a (sd_a),
      .MEM_store_data_b (sd_b),
      .MEM_rf_wdata_a   (rf_a),
      .MEM_rf_wdata_b   (rf_b),
      .stall_dcache     (stall),
`ifdef MISALIGN_CHECK_EN
      .mem_ale_a        (ale_a),
      .mem_ale_b        (ale_b),
`endif
      .dc               (dc)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_bad   = 0;
   int          n_req, n_done, n_stall, post_stall, unstable;
   logic [31:0] rsp_data [4];
   logic [31:0] r_addr [4];
   logic [31:0] r_wdata [4];
   logic [3:0]  r_strb [4];
   logic        r_we [4];
   logic [31:0] done_rf_a, done_rf_b;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [2:0] ta, input logic wa, input logic [31:0] aa,
                          input logic [31:0] sa, input logic [2:0] tb_, input logic wb,
                          input logic [31:0] ab, input logic [31:0] sb);
      type_a = ta; we_a = wa; alu_a = aa; sd_a = sa;
      type_b = tb_; we_b = wb; alu_b = ab; sd_b = sb;
   endtask

   // Drives the dcache side until the DONE cycle, then retires the ops and watches 3 idle cycles.
   task automatic run_txn(input int ready_lat);
      int          wait_cnt = 0;
      int          cyc = 0;
      bit          pend = 1'b0;
      bit          done = 1'b0;
      bit          in_req = 1'b0;
      logic [68:0] first_fields = '0;
      n_req = 0; n_done = 0; n_stall = 0; post_stall = 0; unstable = 0;
      #1;
      while (!done && cyc < 60) begin
         dc.dc_resp_valid = pend;
         dc.dc_resp_rdata = pend ? rsp_data[n_req-1] : 32'h0;
         pend = 1'b0;
         if (stall) begin
            n_stall++;
         end else if (cyc > 0) begin
            done = 1'b1;
            n_done++;
            done_rf_a = rf_a;
            done_rf_b = rf_b;
`ifdef MISALIGN_CHECK_EN
            done_ale_a = ale_a;
`endif
            set_ops(3'b000, 1'b0, alu_a, 32'h0, 3'b000, 1'b0, alu_b, 32'h0);
         end
         if (!done) begin
            if (dc.dc_req_valid) begin
               if (!in_req) begin
                  first_fields = {dc.dc_req_addr, dc.dc_req_we, dc.dc_req_wstrb, dc.dc_req_wdata};
                  in_req = 1'b1;
               end else if (first_fields !=
                            {dc.dc_req_addr, dc.dc_req_we, dc.dc_req_wstrb, dc.dc_req_wdata}) begin
                  unstable++;
               end
               dc.dc_req_ready = (wait_cnt >= ready_lat);
               if (dc.dc_req_ready) begin
                  r_addr[n_req]  = dc.dc_req_addr;
                  r_we[n_req]    = dc.dc_req_we;
                  r_strb[n_req]  = dc.dc_req_wstrb;
                  r_wdata[n_req] = dc.dc_req_wdata;
                  n_req++;
                  pend     = 1'b1;
                  wait_cnt = 0;
                  in_req   = 1'b0;
               end else begin
                  wait_cnt++;
               end
            end else begin
               dc.dc_req_ready = 1'b0;
            end
            step();
            cyc++;
         end
      end
      check_eq("txn_reaches_done", 32'(done), 32'd1);
      dc.dc_resp_valid = 1'b0;
      dc.dc_req_ready  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (stall || dc.dc_req_valid) post_stall++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_ops(3'b000, 1'b0, 32'h1234, 32'h0, 3'b000, 1'b0, 32'h4444, 32'h0);
      dc.dc_req_ready  = 1'b0;
      dc.dc_resp_valid = 1'b0;
      dc.dc_resp_rdata = 32'h0;
      step();
      step();
      rst = 1'b0;
      #1;
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_valid", 32'(dc.dc_req_valid), 32'd0);
      check_eq("rst_rf_a", rf_a, 32'h0000_1234);

      // Single LW, 1-cycle ready and response.
      set_ops(MemLw, 1'b0, 32'h100, 32'h0, MemNone, 1'b0, 32'h4444, 32'h0);
      rsp_data[0] = 32'hDEAD_BEEF;
      run_txn(0);
      check_eq("lw_stall_cycles", n_stall, 3);
      check_eq("lw_nreq", n_req, 1);
      check_eq("lw_addr", r_addr[0], 32'h100);
      check_eq("lw_we", 32'(r_we[0]), 32'd0);
      check_eq("lw_rf_a", done_rf_a, 32'hDEAD_BEEF);
      check_eq("lw_rf_b", done_rf_b, 32'h4444);
      check_eq("lw_post", post_stall, 0);

      set_ops(MemLb, 1'b0, 32'h103, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      rsp_data[0] = 32'h8011_2233;
      run_txn(0);
      check_eq("lb_rf_a", done_rf_a, 32'hFFFF_FF80);
      set_ops(MemLbu, 1'b0, 32'h103, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      run_txn(0);
      check_eq("lbu_rf_a", done_rf_a, 32'h0000_0080);

      // SW in A then LHU in B.
      set_ops(MemLw, 1'b1, 32'h200, 32'h55, MemLhu, 1'b0, 32'h202, 32'h0);
      rsp_data[0] = 32'hFFFF_FFFF;
      rsp_data[1] = 32'hABCD_0000;
      run_txn(0);
      check_eq("ab_nreq", n_req, 2);
      check_eq("ab_addr0", r_addr[0], 32'h200);
      check_eq("ab_we0", 32'(r_we[0]), 32'd1);
      check_eq("ab_strb0", 32'(r_strb[0]), 32'hF);
      check_eq("ab_wdata0", r_wdata[0], 32'h55);
      check_eq("ab_addr1", r_addr[1], 32'h202);
      check_eq("ab_we1", 32'(r_we[1]), 32'd0);
      check_eq("ab_rf_b", done_rf_b, 32'h0000_ABCD);
      check_eq("ab_rf_a", done_rf_a, 32'h200);
      check_eq("ab_stall_cycles", n_stall, 5);
      check_eq("ab_done_once", n_done + post_stall, 1);

      // SB with ready held low for 5 cycles.
      set_ops(MemLb, 1'b1, 32'h301, 32'h12, MemNone, 1'b0, 32'h0, 32'h0);
      rsp_data[0] = 32'h0;
      run_txn(5);
      check_eq("sb_addr", r_addr[0], 32'h301);
      check_eq("sb_strb", 32'(r_strb[0]), 32'h2);
      check_eq("sb_wdata", r_wdata[0], 32'h1212_1212);
      check_eq("sb_stable", unstable, 0);
      check_eq("sb_stall_cycles", n_stall, 8);

      // B-only signed halfword.
      set_ops(MemNone, 1'b0, 32'h5555, 32'h0, MemLh, 1'b0, 32'h100, 32'h0);
      rsp_data[0] = 32'h1234_8001;
      run_txn(0);
      check_eq("lhb_nreq", n_req, 1);
      check_eq("lhb_addr", r_addr[0], 32'h100);
      check_eq("lhb_rf_b", done_rf_b, 32'hFFFF_8001);
      check_eq("lhb_rf_a", done_rf_a, 32'h5555);

      // Reset while waiting for A's response, then a stray response.
      set_ops(MemLw, 1'b0, 32'h100, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      dc.dc_req_ready = 1'b1;
      step();
      check_eq("rstw_valid_areq", 32'(dc.dc_req_valid), 32'd1);
      step();
      check_eq("rstw_stall_await", 32'(stall), 32'd1);
      rst = 1'b1;
      dc.dc_req_ready = 1'b0;
      set_ops(MemNone, 1'b0, 32'h0, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      step();
      rst = 1'b0;
      check_eq("rstw_valid", 32'(dc.dc_req_valid), 32'd0);
      dc.dc_resp_valid = 1'b1;
      dc.dc_resp_rdata = 32'h7777_7777;
      step();
      dc.dc_resp_valid = 1'b0;
      check_eq("rstw_stall", 32'(stall), 32'd0);
      set_ops(MemLw, 1'b0, 32'h100, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      #1;
      check_eq("rstw_no_capture", rf_a, 32'h0);
      set_ops(MemNone, 1'b0, 32'h0, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      step();

`ifdef MISALIGN_CHECK_EN
      set_ops(MemLw, 1'b0, 32'h102, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      rsp_data[0] = 32'hCAFE_F00D;
      run_txn(0);
      check_eq("mis_nreq", n_req, 0);
      check_eq("mis_ale_a", 32'(done_ale_a), 32'd1);
      check_eq("mis_rf_a", done_rf_a, 32'h0);
`else
      set_ops(MemLw, 1'b0, 32'h102, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      rsp_data[0] = 32'hCAFE_F00D;
      run_txn(0);
      check_eq("mis_lw_addr", r_addr[0], 32'h100);
      check_eq("mis_lw_rf_a", done_rf_a, 32'hCAFE_F00D);
      set_ops(MemLhu, 1'b0, 32'h103, 32'h0, MemNone, 1'b0, 32'h0, 32'h0);
      rsp_data[0] = 32'h7FFE_1234;
      run_txn(0);
      check_eq("mis_lh_addr", r_addr[0], 32'h102);
      check_eq("mis_lh_rf_a", done_rf_a, 32'h0000_7FFE);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
